interval_timer_ctrl: RTL and testbench

- Control stage placed directly around the 16-bit flex counter wrapper.
- Drives the counter's clear, count_enable and rollover_val inputs, and consumes its rollover_flag.
- Converts a start request into a programmable train of N periodic ticks of P clock cycles each, followed by a done pulse.
- Supports abort, errors on illegal requests, and reports how many intervals have completed.

---
 rtl/interval_timer_ctrl.sv | 95 +++++++++
 tb/tb_interval_timer_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/interval_timer_ctrl.sv
// rtl/interval_timer_ctrl.sv - control FSM wrapping a flex counter to emit N ticks of P cycles then done
module interval_timer_ctrl #(
  parameter int CNT_BITS = 16,
  parameter int REP_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                stop,
  input  logic [CNT_BITS-1:0] period,
  input  logic [REP_BITS-1:0] num_intervals,
  input  logic                cnt_rollover_flag,
  output logic                cnt_clear,
  output logic                cnt_count_enable,
  output logic [CNT_BITS-1:0] cnt_rollover_val,
  output logic                tick,
  output logic                done,
  output logic                busy,
  output logic                err,
  output logic [REP_BITS-1:0] intervals_done
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t              state;
  state_t              next_state;
  logic [REP_BITS-1:0] n_reg;
  logic [REP_BITS-1:0] done_inc;
  logic                accept;
  logic                reject;
  logic                event_hit;

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    event_hit  = 1'b0;
    done_inc   = intervals_done + REP_BITS'(1);
    case (state)
      IDLE: begin
        if (start) begin
          if ((period != '0) && (num_intervals != '0)) begin
            accept     = 1'b1;
            next_state = ARM;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ARM: next_state = RUN;
      RUN: begin
        // stop wins over a same-cycle rollover, which is dropped entirely
        if (stop) begin
          next_state = IDLE;
        end else if (cnt_rollover_flag) begin
          event_hit = 1'b1;
          if (done_inc == n_reg) begin
            next_state = DONE;
          end
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state            <= IDLE;
      cnt_rollover_val <= '0;
      n_reg            <= '0;
      intervals_done   <= '0;
      tick             <= 1'b0;
      err              <= 1'b0;
    end else begin
      state <= next_state;
      tick  <= event_hit;
      err   <= reject;
      if (accept) begin
        cnt_rollover_val <= period;
        n_reg            <= num_intervals;
        intervals_done   <= '0;
      end
      if (event_hit) begin
        intervals_done <= done_inc;
      end
    end
  end

  assign cnt_count_enable = (state == RUN);
  assign cnt_clear        = (state == ARM) || (state == DONE);
  assign done             = (state == DONE);
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb/tb_interval_timer_ctrl.sv - directed self-checking bench for interval_timer_ctrl with a flex counter model
module tb_interval_timer_ctrl;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic        stop;
  logic [15:0] period;
  logic [7:0]  num_intervals;
  logic        cnt_rollover_flag;
  logic        cnt_clear;
  logic        cnt_count_enable;
  logic [15:0] cnt_rollover_val;
  logic        tick;
  logic        done;
  logic        busy;
  logic        err;
  logic [7:0]  intervals_done;
  logic [15:0] cnt;

  int n_checks;
  int n_fail;

  logic [31:0] tick_m, done_m, busy_m, en_m, clr_m;

  interval_timer_ctrl #(.CNT_BITS(16), .REP_BITS(8)) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .start             (start),
    .stop              (stop),
    .period            (period),
    .num_intervals     (num_intervals),
    .cnt_rollover_flag (cnt_rollover_flag),
    .cnt_clear         (cnt_clear),
    .cnt_count_enable  (cnt_count_enable),
    .cnt_rollover_val  (cnt_rollover_val),
    .tick              (tick),
    .done              (done),
    .busy              (busy),
    .err               (err),
    .intervals_done    (intervals_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flex counter: clear to 0, count 1..P then wrap to 1, flag while count==P
  always_ff @(posedge clk) begin
    if (n_rst) cnt <= '0;
    else if (cnt_clear) cnt <= '0;
    else if (cnt_count_enable) cnt <= (cnt == cnt_rollover_val) ? 16'd1 : cnt + 16'd1;
  end
  assign cnt_rollover_flag = (cnt == cnt_rollover_val);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_tick"}, {31'b0, tick}, 32'd0);
    check_eq({tag, "_done"}, {31'b0, done}, 32'd0);
    check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check_eq({tag, "_err"}, {31'b0, err}, 32'd0);
    check_eq({tag, "_clear"}, {31'b0, cnt_clear}, 32'd0);
    check_eq({tag, "_en"}, {31'b0, cnt_count_enable}, 32'd0);
    check_eq({tag, "_rval"}, {16'b0, cnt_rollover_val}, 32'd0);
    check_eq({tag, "_idone"}, {24'b0, intervals_done}, 32'd0);
  endtask

  // start is sampled at E0; bit k of each mask is the output seen just after edge Ek
  task automatic run_capture(input logic [15:0] p, input logic [7:0] n, input int cycles,
                             input int stop_at, input int poke_at);
    tick_m = '0; done_m = '0; busy_m = '0; en_m = '0; clr_m = '0;
    period = p;
    num_intervals = n;
    start = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      step();
      tick_m[k] = tick;
      done_m[k] = done;
      busy_m[k] = busy;
      en_m[k]   = cnt_count_enable;
      clr_m[k]  = cnt_clear;
      if (k == 0) start = 1'b0;
      stop = (k == stop_at);
      if (k == poke_at) begin
        start = 1'b1;
        period = 16'd9;
        num_intervals = 8'd7;
      end else if (k == poke_at + 1) begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    n_rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    period = '0;
    num_intervals = '0;
    step();
    step();
    check_all_zero("reset");
    n_rst = 1'b0;

    // P=3, N=2
    run_capture(16'd3, 8'd2, 12, -1, -1);
    check_eq("p3_tick", tick_m, 32'h120);
    check_eq("p3_done", done_m, 32'h100);
    check_eq("p3_busy", busy_m, 32'h1FF);
    check_eq("p3_clear", clr_m, 32'h101);
    check_eq("p3_en", en_m, 32'h0FE);
    check_eq("p3_idone", {24'b0, intervals_done}, 32'd2);
    check_eq("p3_rval", {16'b0, cnt_rollover_val}, 32'd3);

    // P=1, N=4: back-to-back ticks
    run_capture(16'd1, 8'd4, 10, -1, -1);
    check_eq("p1_tick", tick_m, 32'h78);
    check_eq("p1_done", done_m, 32'h40);
    check_eq("p1_en", en_m, 32'h3E);
    check_eq("p1_busy", busy_m, 32'h7F);
    check_eq("p1_idone", {24'b0, intervals_done}, 32'd4);

    // illegal starts from a fresh reset
    n_rst = 1'b1;
    step();
    n_rst = 1'b0;
    start = 1'b1; period = 16'd0; num_intervals = 8'd5;
    step();
    start = 1'b0;
    check_eq("p0_err", {31'b0, err}, 32'd1);
    check_eq("p0_busy", {31'b0, busy}, 32'd0);
    check_eq("p0_rval", {16'b0, cnt_rollover_val}, 32'd0);
    step();
    check_eq("p0_err_clr", {31'b0, err}, 32'd0);
    start = 1'b1; period = 16'd10; num_intervals = 8'd0;
    step();
    start = 1'b0;
    check_eq("n0_err", {31'b0, err}, 32'd1);
    check_eq("n0_busy", {31'b0, busy}, 32'd0);
    check_eq("n0_rval", {16'b0, cnt_rollover_val}, 32'd0);
    step();
    check_eq("n0_err_clr", {31'b0, err}, 32'd0);
    check_eq("n0_busy2", {31'b0, busy}, 32'd0);

    // P=5, N=3, stop during the second flag (cycle E11..E12)
    run_capture(16'd5, 8'd3, 14, 11, -1);
    check_eq("stop_tick", tick_m, 32'h80);
    check_eq("stop_done", done_m, 32'h0);
    check_eq("stop_busy", busy_m, 32'hFFF);
    check_eq("stop_en", en_m, 32'hFFE);
    check_eq("stop_idone", {24'b0, intervals_done}, 32'd1);
    check_eq("stop_rval", {16'b0, cnt_rollover_val}, 32'd5);

    // P=4, N=3, reset mid-RUN then immediate restart
    run_capture(16'd4, 8'd3, 4, -1, -1);
    check_eq("mid_en", {31'b0, cnt_count_enable}, 32'd1);
    n_rst = 1'b1;
    step();
    check_all_zero("midrst");
    n_rst = 1'b0;

    // restart; period/start changes mid-RUN must be ignored
    run_capture(16'd4, 8'd3, 17, -1, 5);
    check_eq("re_accept", busy_m[0] & clr_m[0], 1'b1);
    check_eq("poke_tick", tick_m, 32'h4440);
    check_eq("poke_done", done_m, 32'h4000);
    check_eq("poke_busy", busy_m, 32'h7FFF);
    check_eq("poke_rval", {16'b0, cnt_rollover_val}, 32'd4);
    check_eq("poke_idone", {24'b0, intervals_done}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
